// File: rtl/mdu_pkg.sv
// Shared types and constants for the M-extension sequential divider.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  // Encoding matches funct3[1:0] of the divide instructions.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/mdu_div_seq_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shift {rem,quo} left one bit, then subtract the divisor when it fits.
  always_comb begin
    // NOTE: every output gets a default before the conditional update so no latch is inferred.
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    rem_o   = shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], 1'b0};
    if (shifted >= {1'b0, divisor_i}) begin
      rem_o    = diff[XLEN-1:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mdu_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: IDLE -> CALC (32 iterations) -> DONE.
// Optional build macro MDU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip CALC and go straight to DONE from IDLE. Results are identical either way.
module mdu_div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import mdu_pkg::*;

  localparam logic [XLEN-1:0]  SIGN_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_SET   = '1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN-1);

  div_state_e       state_q;
  div_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q;     // quotient needs negation
  logic             neg_r_q;     // remainder needs negation (dividend was negative)
  logic             by_zero_q;
  logic             ovf_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  result_q;
  logic             done_q;

  logic [XLEN-1:0]  rem_d;
  logic [XLEN-1:0]  quo_d;

  // Decode of the incoming request, used only on the accepting edge.
  logic             in_signed;
  logic             in_neg_a;
  logic             in_neg_b;
  logic [XLEN-1:0]  in_abs_a;
  logic [XLEN-1:0]  in_abs_b;
  logic             in_by_zero;
  logic             in_ovf;

  assign in_signed  = ~op[0];
  assign in_neg_a   = in_signed & dividend[XLEN-1];
  assign in_neg_b   = in_signed & divisor[XLEN-1];
  assign in_abs_a   = in_neg_a ? -dividend : dividend;
  assign in_abs_b   = in_neg_b ? -divisor  : divisor;
  assign in_by_zero = (divisor == '0);
  assign in_ovf     = in_signed & (dividend == SIGN_MIN) & (divisor == ALL_SET);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // Apply signs to the magnitudes, then let the special cases override.
  // With a zero divisor the restoring loop leaves |dividend| in the remainder,
  // so re-applying the dividend sign returns the dividend unmodified.
  function automatic logic [XLEN-1:0] fix_up(
    input logic            want_rem,
    input logic            neg_quo,
    input logic            neg_rem,
    input logic            by_zero,
    input logic            overflow,
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag
  );
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = neg_quo ? -q_mag : q_mag;
    r = neg_rem ? -r_mag : r_mag;
    if (by_zero) begin
      q = ALL_SET;
    end
    if (overflow) begin
      q = SIGN_MIN;
      r = '0;
    end
    return want_rem ? r : q;
  endfunction

  // Sequencer: request capture, iteration, result fix-up and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the datapath registers are reset as well, so result reads 0 after reset.
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      by_zero_q <= 1'b0;
      ovf_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      done_q <= 1'b0;
      if (kill) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              op_q      <= div_op_e'(op);
              neg_q_q   <= in_neg_a ^ in_neg_b;
              neg_r_q   <= in_neg_a;
              by_zero_q <= in_by_zero;
              ovf_q     <= in_ovf;
              rem_q     <= '0;
              quo_q     <= in_abs_a;
              divisor_q <= in_abs_b;
              cnt_q     <= '0;
`ifdef MDU_DIV_EARLY_OUT_EN
              if (in_by_zero || in_ovf) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                result_q <= fix_up(op[1], in_neg_a ^ in_neg_b, in_neg_a,
                                   in_by_zero, in_ovf, ALL_SET, in_abs_a);
              end else begin
                state_q <= CALC;
              end
`else
              state_q <= CALC;
`endif
            end
          end
          CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= fix_up(op_q[1], neg_q_q, neg_r_q, by_zero_q, ovf_q,
                                 quo_d, rem_d);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = (state_q != IDLE);
  // Combinational from start so the requesting instruction holds in its first cycle.
  assign stall  = ((state_q == IDLE) & start & ~kill) | (state_q == CALC);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq: vector table through a scoreboard,
// plus hand-written kill, start/kill, held-start and async-reset sequences.
module tb_mdu_div_seq;

  import mdu_pkg::*;

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = 32;
`endif
  localparam int NORMAL_LAT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          start_cyc;
    int          lat;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[16];

  mdu_div_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .kill     (kill),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (result 0x%08h)", result);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", cyc - e.start_cyc, e.lat);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && (sb.size() != 0 || busy); i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    sb.push_back('{exp, cyc + 1, lat});
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int stall_hi;
    int saved;

    vecs[0]  = '{DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0};
    vecs[1]  = '{REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{REMU, 32'hFFFF_FFF9, 32'd2,          32'd1,         1'b0};
    vecs[3]  = '{DIVU, 32'd5,         32'd0,          32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{REM,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 1'b1};
    vecs[5]  = '{DIV,  INT_MIN,       ALL_ONES,       INT_MIN,       1'b1};
    vecs[6]  = '{REM,  INT_MIN,       ALL_ONES,       32'd0,         1'b1};
    vecs[7]  = '{DIV,  32'd20,        32'hFFFF_FFFD,  32'hFFFF_FFFA, 1'b0};
    vecs[8]  = '{REM,  32'd20,        32'hFFFF_FFFD,  32'd2,         1'b0};
    vecs[9]  = '{DIVU, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{REMU, 32'd0,         32'd5,          32'd0,         1'b0};
    vecs[11] = '{DIV,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{REMU, 32'd12345,     32'd0,          32'd12345,     1'b1};
    vecs[13] = '{DIVU, INT_MIN,       ALL_ONES,       32'd0,         1'b0};
    vecs[14] = '{REM,  32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE, 1'b0};
    vecs[15] = '{DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'b0, busy},  32'd0);
    check("rst_stall",  {31'b0, stall}, 32'd0);
    check("rst_done",   {31'b0, done},  32'd0);
    check("rst_result", result,         32'd0);
    rst = 1'b1;

    // DIVU 100/7: stall through CALC, one-cycle done, idle afterwards.
    @(negedge clk);
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    #1;
    check("t0_stall", {31'b0, stall}, 32'd1);
    sb.push_back('{32'd14, cyc + 1, NORMAL_LAT});
    stall_hi = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (stall) stall_hi++;
    end
    check("calc_stall_cycles", stall_hi, 32'd32);
    @(negedge clk);
    check("done_high",   {31'b0, done},  32'd1);
    check("done_stall",  {31'b0, stall}, 32'd0);
    check("done_busy",   {31'b0, busy},  32'd1);
    @(negedge clk);
    check("done_pulse_end", {31'b0, done}, 32'd0);
    check("post_busy",      {31'b0, busy}, 32'd0);
    wait_idle();

    // Table-driven operations.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].special ? SPECIAL_LAT : NORMAL_LAT);
    end

    // Kill at T10 during CALC, then a fresh DIVU 9/3 started at T12.
    saved = done_cnt;
    @(negedge clk);
    op = DIVU; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    run_op(DIVU, 32'd9, 32'd3, 32'd3, NORMAL_LAT);
    check("kill_done_count", done_cnt - saved, 32'd1);

    // start and kill together in IDLE: nothing happens.
    @(negedge clk);
    op = DIVU; dividend = 32'd8; divisor = 32'd2; start = 1'b1; kill = 1'b1;
    #1;
    check("startkill_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    check("startkill_busy", {31'b0, busy}, 32'd0);
    start = 1'b0; kill = 1'b0;

    // start held through the whole operation: exactly one done.
    saved = done_cnt;
    @(negedge clk);
    op = DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    sb.push_back('{32'd10, cyc + 1, NORMAL_LAT});
    repeat (33) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("held_start_dones", done_cnt - saved, 32'd1);
    check("held_start_busy",  {31'b0, busy},    32'd0);

    // Asynchronous reset mid-CALC, between clock edges.
    saved = done_cnt;
    @(negedge clk);
    op = DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("areset_busy",   {31'b0, busy},  32'd0);
    check("areset_stall",  {31'b0, stall}, 32'd0);
    check("areset_done",   {31'b0, done},  32'd0);
    check("areset_result", result,         32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("areset_no_done", done_cnt - saved, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
